nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 108 ++++++++++
 tb/tb_nibble_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: a single 4-bit ripple slice is reused over
// WIDTH/4 cycles, LSB nibble first, to form a WIDTH-bit sum or difference.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin_in,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout_out,
  output logic             ovf,
  output logic [1:0]       o_dbg_state
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_op;
  logic [WIDTH-1:0] r_b_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CW+1:0]    w_lsb;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_slice;
  logic [3:0]       w_low;
  logic             w_last;

  // Single 4-bit slice; w_low exposes the carry into bit 3 for overflow.
  assign w_lsb   = {r_cnt, 2'b00};
  assign w_a_nib = r_a_op[w_lsb +: 4];
  assign w_b_nib = r_b_op[w_lsb +: 4];
  assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, r_carry};
  assign w_low   = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b0, r_carry};
  assign w_last  = (r_cnt == LAST_NIB);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign ready       = (r_state == IDLE);
  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_op   <= '0;
      r_b_op   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      S        <= '0;
      Cout_out <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1; Cin_in is not used in that case.
            r_a_op  <= A;
            r_b_op  <= sub ? ~B : B;
            r_carry <= sub ? 1'b1 : Cin_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          S[w_lsb +: 4] <= w_slice[3:0];
          r_carry       <= w_slice[4];
          r_cnt         <= r_cnt + 1'b1;
          if (w_last) begin
            Cout_out <= w_slice[4];
            ovf      <= w_low[3] ^ w_slice[4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): hand-computed vectors,
// immediate assertions at every comparison, one summary line at the end.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] s_out;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  logic [W:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (a_in),
    .B          (b_in),
    .Cin_in     (cin),
    .sub        (sub),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .S          (s_out),
    .Cout_out   (cout),
    .ovf        (ovf),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, measure latency, check the result.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic sb, input logic [W-1:0] exp_s,
                       input logic exp_c, input logic exp_v);
    int lat;
    a_in = a; b_in = b; cin = c; sub = sb; start = 1'b1;
    tick();
    start = 1'b0;
    a_in = 16'hDEAD; b_in = 16'hBEEF; cin = ~c; sub = ~sb;
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_s"}, s_out, exp_s);
    check({tag, "_cout"}, cout, exp_c);
    check({tag, "_ovf"}, ovf, exp_v);
    tick();
    check({tag, "_done_width"}, done, 0);
    check({tag, "_ready_after"}, ready, 1);
  endtask

  logic [W-1:0] tbl_a[4] = '{16'h1111, 16'h8000, 16'hABCD, 16'hFFFF};
  logic [W-1:0] tbl_b[4] = '{16'h2222, 16'h8000, 16'h1234, 16'hFFFF};
  logic [W:0]   tbl_r[4] = '{17'h03333, 17'h10000, 17'h0BE01, 17'h1FFFE};

  initial begin
    int lat;
    int n_done;
    int n_busy;
    int n_acc;
    int n_res;
    int acc_cyc[4];
    logic [W:0] exp_r;

    // Reset with start held high: must not be accepted.
    rst = 1'b1; start = 1'b1; a_in = 16'h1234; b_in = 16'h4321; cin = 1'b1; sub = 1'b0;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s_out, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_stays", ready, 1);

    do_op("add_plain", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start pulsed during the second RUN cycle is ignored.
    a_in = 16'h0001; b_in = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a_in = 16'hAAAA; b_in = 16'h5555; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 2;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("busy_start_latency", lat, 4);
    check("busy_start_s", s_out, 16'h0002);
    check("busy_start_cout", cout, 0);
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("busy_start_extra_done", n_done, 0);
    check("busy_start_extra_busy", n_busy, 0);

    // Reset after the second RUN edge abandons the operation.
    a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", ready, 1);
    check("midrst_s", s_out, 0);
    check("midrst_cout", cout, 0);
    check("midrst_done", done, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    do_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Back-to-back with start held high; operands change every cycle.
    n_acc = 0; n_res = 0; cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 60 && n_res < 4; cyc++) begin
      tick();
      if (done) begin
        if (exp_q.size() > 0) begin
          exp_r = exp_q.pop_front();
          check("b2b_result", {cout, s_out}, exp_r);
        end else begin
          check("b2b_unexpected_done", 1, 0);
        end
        n_res++;
      end
      if (ready && n_acc < 4) begin
        a_in = tbl_a[n_acc]; b_in = tbl_b[n_acc]; start = 1'b1;
        exp_q.push_back(tbl_r[n_acc]);
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else begin
        a_in = 16'(cyc * 16'h0731); b_in = ~16'(cyc); start = (n_acc < 4);
      end
    end
    start = 1'b0;
    check("b2b_results", n_res, 4);
    for (int k = 1; k < 4; k++) check("b2b_spacing", acc_cyc[k] - acc_cyc[k-1], 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
